instr_fetch_buffer: RTL and testbench

Instruction fetch front end that sits directly upstream of the instruction cache.
- Holds the fetch PC and issues sequential word fetches over the cache's req/gnt/rvalid interface, with at most one transaction outstanding.
- Buffers returned instructions, each with its PC, in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding stale responses.

---
 rtl/instr_fetch_buffer_if.sv | 29 ++
 rtl/instr_fetch_buffer.sv | 134 +++++++++++++
 tb/tb_instr_fetch_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_buffer_if.sv
// Bundles the redirect, decode and instruction-cache signals of the fetch front end.
// master: the fetch buffer itself; slave: the surrounding decode/cache environment.
interface instr_fetch_buffer_if;
    logic        redirect_valid;
    logic [31:0] redirect_adr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        cached_instr_req;
    logic [31:0] cached_instr_adr;
    logic        cached_instr_gnt;
    logic        cached_instr_rvalid;
    logic [31:0] cached_instr_read;

    modport master (
        input  redirect_valid, redirect_adr, instr_ready,
               cached_instr_gnt, cached_instr_rvalid, cached_instr_read,
        output instr_valid, instr_data, instr_pc,
               cached_instr_req, cached_instr_adr
    );

    modport slave (
        output redirect_valid, redirect_adr, instr_ready,
               cached_instr_gnt, cached_instr_rvalid, cached_instr_read,
        input  instr_valid, instr_data, instr_pc,
               cached_instr_req, cached_instr_adr
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Sequential instruction fetcher with one outstanding cache transaction, a PC-tagged
// instruction FIFO toward decode, and redirect handling that flushes and drops stale data.
module instr_fetch_buffer #(
    parameter int unsigned LOG_DEPTH = 2,
    parameter logic [31:0] BOOT_ADR  = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  res,
    instr_fetch_buffer_if.master bus
);
    localparam logic [LOG_DEPTH:0] DEPTH = {1'b1, {LOG_DEPTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID} state_e;

    state_e               state_q, state_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                 discard_q, discard_d;
    logic                 pending_q, pending_d;
    logic [31:0]          pending_pc_q, pending_pc_d;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [31:0]          req_pc_q, req_pc_d;
    logic                 req_q, req_d;
    logic [31:0]          data_mem_q [2**LOG_DEPTH];
    logic [31:0]          pc_mem_q   [2**LOG_DEPTH];

    logic                 push, pop;
    logic [31:0]          redirect_pc;
    logic [LOG_DEPTH:0]   count_after_pop, count_after_push;
    logic                 unused_adr_lsb;

    assign redirect_pc      = {bus.redirect_adr[31:2], 2'b00};
    assign unused_adr_lsb   = ^bus.redirect_adr[1:0];
    assign pop              = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
    assign push             = (state_q == WAIT_RVALID) && bus.cached_instr_rvalid
                              && !discard_q && !bus.redirect_valid;
    assign count_after_pop  = count_q - (LOG_DEPTH+1)'(pop);
    assign count_after_push = count_after_pop + (LOG_DEPTH+1)'(push);

    always_comb begin
        state_d      = state_q;
        count_d      = count_after_push;
        rd_ptr_d     = rd_ptr_q + LOG_DEPTH'(pop);
        wr_ptr_d     = wr_ptr_q + LOG_DEPTH'(push);
        discard_d    = discard_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.redirect_valid || (count_after_pop < DEPTH)) state_d = REQ;
            end
            REQ: begin
                if (bus.cached_instr_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = pending_q ? pending_pc_q : fetch_pc_q + 32'd4;
                    pending_d  = 1'b0;
                    state_d    = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (bus.cached_instr_rvalid) begin
                    discard_d = 1'b0;
                    if (discard_q || bus.redirect_valid || (count_after_push < DEPTH))
                        state_d = REQ;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A request already on the bus cannot be withdrawn, so the new PC waits for its grant.
        if (bus.redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            if ((state_q == REQ) && !bus.cached_instr_gnt) begin
                pending_d    = 1'b1;
                pending_pc_d = redirect_pc;
                discard_d    = 1'b1;
            end else begin
                fetch_pc_d = redirect_pc;
                if ((state_q == REQ) || ((state_q == WAIT_RVALID) && !bus.cached_instr_rvalid))
                    discard_d = 1'b1;
            end
        end
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            discard_q    <= 1'b0;
            pending_q    <= 1'b0;
            pending_pc_q <= BOOT_ADR;
            fetch_pc_q   <= BOOT_ADR;
            req_pc_q     <= BOOT_ADR;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            discard_q    <= discard_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            req_q        <= req_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= bus.cached_instr_read;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!res && push) full_push_a: assert (count_after_pop < DEPTH);
    end

    assign bus.cached_instr_req = req_q;
    assign bus.cached_instr_adr = fetch_pc_q;
    assign bus.instr_valid      = (count_q != '0);
    assign bus.instr_data       = data_mem_q[rd_ptr_q];
    assign bus.instr_pc         = pc_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: an always-hit cache model with one-cycle grant
// latency plus stall knobs, a redirect vector table and hand-written corner sequences.
module tb_instr_fetch_buffer;
    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    instr_fetch_buffer_if bus();

    instr_fetch_buffer #(.LOG_DEPTH(2), .BOOT_ADR(32'h0000_0100)) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    typedef struct {
        int          cond;
        logic [31:0] adr;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } vec_t;

    int          n_vec = 0;
    int          n_fail = 0;
    int          n_gnt = 0;
    int          req_age = 0;
    bit          resp_pend = 1'b0;
    bit          hold_gnt = 1'b0;
    bit          hold_rvalid = 1'b0;
    logic [31:0] resp_adr = 32'h0;
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    vec_t        vecs[6];

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: record pops, advance the cache model, drive next-cycle cache inputs.
    task automatic tick();
        logic        gnt_now, req_now, rv_now;
        logic [31:0] adr_now;
        gnt_now = bus.cached_instr_gnt;
        req_now = bus.cached_instr_req;
        rv_now  = bus.cached_instr_rvalid;
        adr_now = bus.cached_instr_adr;
        if (!res && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
            got_pc.push_back(bus.instr_pc);
            got_data.push_back(bus.instr_data);
        end
        if (!res && gnt_now && req_now) n_gnt++;
        @(posedge clk);
        #1;
        if (res) begin
            resp_pend = 1'b0;
            req_age   = 0;
        end else begin
            if (rv_now) resp_pend = 1'b0;
            if (gnt_now && req_now) begin
                resp_pend = 1'b1;
                resp_adr  = adr_now;
            end
            if (bus.cached_instr_req && req_now && !gnt_now) req_age++;
            else req_age = 0;
        end
        bus.cached_instr_rvalid = resp_pend && !hold_rvalid && !res;
        bus.cached_instr_read   = bus.cached_instr_rvalid ? model_data(resp_adr) : 32'h0;
        bus.cached_instr_gnt    = bus.cached_instr_req && (req_age >= 1) && !hold_gnt;
    endtask

    task automatic run_until_pops(input int n, input int budget);
        int b = budget;
        while (got_pc.size() < n && b > 0) begin
            tick();
            b--;
        end
        check("pop_count", 32'(got_pc.size()), 32'(n));
    endtask

    function automatic bit cond_met(input int c);
        case (c)
            0:       return bus.cached_instr_req && !bus.cached_instr_gnt;
            1, 3:    return bus.cached_instr_req && bus.cached_instr_gnt;
            2:       return bus.cached_instr_rvalid && bus.instr_valid;
            default: return !bus.cached_instr_req && !resp_pend && bus.instr_valid
                            && !bus.cached_instr_rvalid;
        endcase
    endfunction

    task automatic wait_cond(input int c, input int budget);
        int b = budget;
        while (!cond_met(c) && b > 0) begin
            tick();
            b--;
        end
        check("cond_reached", 32'(cond_met(c)), 32'd1);
    endtask

    initial begin
        logic [31:0] old_adr;

        vecs[0] = '{0, 32'h0000_0400, 32'h0000_0400, 32'h0000_0404};
        vecs[1] = '{1, 32'h0000_2003, 32'h0000_2000, 32'h0000_2004};
        vecs[2] = '{2, 32'h0000_3001, 32'h0000_3000, 32'h0000_3004};
        vecs[3] = '{3, 32'h0000_2003, 32'h0000_2000, 32'h0000_2004};
        vecs[4] = '{4, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[5] = '{0, 32'h8000_0008, 32'h8000_0008, 32'h8000_000C};

        res                     = 1'b1;
        bus.redirect_valid      = 1'b0;
        bus.redirect_adr        = 32'h0;
        bus.instr_ready         = 1'b0;
        bus.cached_instr_gnt    = 1'b0;
        bus.cached_instr_rvalid = 1'b0;
        bus.cached_instr_read   = 32'h0;
        tick();
        tick();
        res = 1'b0;
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_req", 32'(bus.cached_instr_req), 32'd0);
        check("rst_adr", bus.cached_instr_adr, 32'h0000_0100);

        // First fetch: req at t, gnt t+1, rvalid t+2, instr_valid t+3.
        tick();
        check("boot_req", 32'(bus.cached_instr_req), 32'd1);
        check("boot_adr", bus.cached_instr_adr, 32'h0000_0100);
        tick();
        check("lat_t1_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("lat_t3_valid", 32'(bus.instr_valid), 32'd1);
        check("lat_t3_pc", bus.instr_pc, 32'h0000_0100);
        check("lat_t3_data", bus.instr_data, model_data(32'h0000_0100));

        repeat (20) tick();
        check("fill_gnts", 32'(n_gnt), 32'd4);
        check("fill_req", 32'(bus.cached_instr_req), 32'd0);

        n_gnt = 0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        repeat (12) tick();
        check("refill_gnts", 32'(n_gnt), 32'd1);
        check("refill_req", 32'(bus.cached_instr_req), 32'd0);
        check("refill_popped_pc", got_pc[0], 32'h0000_0100);

        got_pc.delete();
        got_data.delete();
        bus.instr_ready = 1'b1;
        run_until_pops(6, 60);
        for (int i = 0; i < 6; i++) begin
            if (i < got_pc.size()) begin
                check("drain_pc", got_pc[i], 32'h0000_0104 + 32'(4 * i));
                check("drain_data", got_data[i], model_data(32'h0000_0104 + 32'(4 * i)));
            end
        end

        for (int v = 0; v < 6; v++) begin
            bus.instr_ready = 1'b0;
            wait_cond(vecs[v].cond, 60);
            if (vecs[v].cond == 3) begin
                tick();
                hold_rvalid             = 1'b1;
                bus.cached_instr_rvalid = 1'b0;
                bus.cached_instr_read   = 32'h0;
            end
            bus.redirect_valid = 1'b1;
            bus.redirect_adr   = vecs[v].adr;
            bus.instr_ready    = 1'b1;
            tick();
            bus.redirect_valid = 1'b0;
            hold_rvalid        = 1'b0;
            check("redir_flush_valid", 32'(bus.instr_valid), 32'd0);
            got_pc.delete();
            got_data.delete();
            run_until_pops(2, 80);
            if (got_pc.size() >= 2) begin
                check("redir_pc0", got_pc[0], vecs[v].exp_pc0);
                check("redir_data0", got_data[0], model_data(vecs[v].exp_pc0));
                check("redir_pc1", got_pc[1], vecs[v].exp_pc1);
            end
        end

        // Redirect while the grant is stalled: old address must stay on the bus.
        hold_gnt = 1'b1;
        bus.instr_ready = 1'b1;
        wait_cond(0, 20);
        old_adr = bus.cached_instr_adr;
        bus.redirect_valid = 1'b1;
        bus.redirect_adr   = 32'h0000_0400;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_req", 32'(bus.cached_instr_req), 32'd1);
            check("stall_adr", bus.cached_instr_adr, old_adr);
            tick();
        end
        hold_gnt = 1'b0;
        got_pc.delete();
        got_data.delete();
        run_until_pops(1, 60);
        if (got_pc.size() >= 1) begin
            check("stall_first_pc", got_pc[0], 32'h0000_0400);
            check("stall_first_data", got_data[0], model_data(32'h0000_0400));
        end

        // Reset while a response is outstanding.
        bus.instr_ready = 1'b0;
        wait_cond(1, 20);
        tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst_req", 32'(bus.cached_instr_req), 32'd0);
        check("midrst_adr", bus.cached_instr_adr, 32'h0000_0100);
        tick();
        check("midrst_req_after", 32'(bus.cached_instr_req), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
